// File: rtl/hart_irq_if.sv
// CSR request/response and IRQ handshake bundle between the core (master) and hart_irq (slave).
interface hart_irq_if;
  logic        i_csr_req_valid;
  logic        i_csr_req_write;
  logic [11:0] i_csr_req_addr;
  logic [63:0] i_csr_req_wdata;
  logic        o_csr_resp_valid;
  logic [63:0] o_csr_resp_rdata;
  logic        o_csr_resp_exception;
  logic        o_irq_valid;
  logic [3:0]  o_irq_cause;
  logic        i_irq_ready;

  modport master (
    output i_csr_req_valid, i_csr_req_write, i_csr_req_addr, i_csr_req_wdata, i_irq_ready,
    input  o_csr_resp_valid, o_csr_resp_rdata, o_csr_resp_exception, o_irq_valid, o_irq_cause
  );

  modport slave (
    input  i_csr_req_valid, i_csr_req_write, i_csr_req_addr, i_csr_req_wdata, i_irq_ready,
    output o_csr_resp_valid, o_csr_resp_rdata, o_csr_resp_exception, o_irq_valid, o_irq_cause
  );
endinterface

// File: rtl/hart_irq.sv
// Per-hart M-mode interrupt controller: mip/mie/time CSRs, prioritised IRQ handshake, WFI wake.
// Optional accepted-IRQ counter at CSR 0x7C0 is enabled by defining HART_IRQ_COUNTER_EN.
module hart_irq #(
  parameter int cpu_total = 4,
  parameter int hartid    = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [cpu_total-1:0] i_msip,
  input  logic [cpu_total-1:0] i_mtip,
  input  logic                 i_meip,
  input  logic                 i_seip,
  input  logic [63:0]          i_mtimer,
  input  logic                 i_mstatus_mie,
  input  logic                 i_mret,
  output logic                 o_wfi_wake,
  hart_irq_if.slave            bus
);

  localparam logic [11:0] CSR_MIE  = 12'h304;
  localparam logic [11:0] CSR_MIP  = 12'h344;
  localparam logic [11:0] CSR_TIME = 12'hC01;
  localparam logic [11:0] CSR_CNT  = 12'h7C0;
  localparam logic [63:0] IRQ_MASK = 64'h0000_0000_0000_0A88;
  localparam logic [cpu_total-1:0] HART_SEL = cpu_total'(1) << hartid;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    INSERVICE
  } state_e;

  state_e state_q, state_d;

  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic        meip_q, meip_d;
  logic        seip_q, seip_d;
  logic        sseip_q, sseip_d;
  logic [63:0] mie_q, mie_d;
  logic [63:0] time_q, time_d;
  logic [3:0]  cause_q, cause_d;
  logic        wfi_q, wfi_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_exc_q, resp_exc_d;
`ifdef HART_IRQ_COUNTER_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  logic [63:0] mip_val;
  logic [63:0] pending;
  logic        take_irq;
  logic        accept;
  logic [3:0]  prio_cause;
  logic [63:0] csr_rd;
  logic        csr_exc;
  logic        csr_wr;
  logic        irq_valid;
  logic [3:0]  irq_cause;

  always_comb begin
    mip_val     = '0;
    mip_val[3]  = msip_q;
    mip_val[7]  = mtip_q;
    mip_val[9]  = seip_q | sseip_q;
    mip_val[11] = meip_q;
    pending     = mip_val & mie_q;
    take_irq    = (state_q == IDLE) && i_mstatus_mie && (|pending);
    accept      = (state_q == REQUEST) && bus.i_irq_ready;
    if (pending[11])     prio_cause = 4'd11;
    else if (pending[3]) prio_cause = 4'd3;
    else if (pending[7]) prio_cause = 4'd7;
    else                 prio_cause = 4'd9;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (take_irq) state_d = REQUEST;
      REQUEST:   if (bus.i_irq_ready) state_d = INSERVICE;
      INSERVICE: if (i_mret) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_valid = (state_q == REQUEST);
    irq_cause = cause_q;
  end

  // CSR decode sees only registered state, so a same-cycle mie write never affects evaluation
  always_comb begin
    csr_wr  = bus.i_csr_req_valid && bus.i_csr_req_write;
    csr_rd  = '0;
    csr_exc = 1'b0;
    mie_d   = mie_q;
    sseip_d = sseip_q;
`ifdef HART_IRQ_COUNTER_EN
    cnt_d   = accept ? cnt_q + 32'd1 : cnt_q;
`endif
    case (bus.i_csr_req_addr)
      CSR_MIE: begin
        csr_rd = mie_q;
        if (csr_wr) mie_d = bus.i_csr_req_wdata & IRQ_MASK;
      end
      CSR_MIP: begin
        csr_rd = mip_val;
        if (csr_wr) sseip_d = bus.i_csr_req_wdata[9];
      end
      CSR_TIME: begin
        csr_rd = time_q;
        if (csr_wr) csr_exc = 1'b1;
      end
`ifdef HART_IRQ_COUNTER_EN
      CSR_CNT: begin
        csr_rd = {32'd0, cnt_q};
        if (csr_wr) cnt_d = bus.i_csr_req_wdata[31:0];
      end
`endif
      default: csr_exc = 1'b1;
    endcase

    resp_valid_d = bus.i_csr_req_valid;
    resp_exc_d   = bus.i_csr_req_valid && csr_exc;
    resp_rdata_d = (bus.i_csr_req_valid && !csr_exc) ? csr_rd : '0;

    msip_d  = |(i_msip & HART_SEL);
    mtip_d  = |(i_mtip & HART_SEL);
    meip_d  = i_meip;
    seip_d  = i_seip;
    time_d  = i_mtimer;
    wfi_d   = |pending;
    cause_d = take_irq ? prio_cause : cause_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      msip_q       <= 1'b0;
      mtip_q       <= 1'b0;
      meip_q       <= 1'b0;
      seip_q       <= 1'b0;
      sseip_q      <= 1'b0;
      mie_q        <= '0;
      time_q       <= '0;
      cause_q      <= '0;
      wfi_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_exc_q   <= 1'b0;
`ifdef HART_IRQ_COUNTER_EN
      cnt_q        <= '0;
`endif
    end else begin
      msip_q       <= msip_d;
      mtip_q       <= mtip_d;
      meip_q       <= meip_d;
      seip_q       <= seip_d;
      sseip_q      <= sseip_d;
      mie_q        <= mie_d;
      time_q       <= time_d;
      cause_q      <= cause_d;
      wfi_q        <= wfi_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
`ifdef HART_IRQ_COUNTER_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.o_irq_valid          = irq_valid;
  assign bus.o_irq_cause          = irq_cause;
  assign bus.o_csr_resp_valid     = resp_valid_q;
  assign bus.o_csr_resp_rdata     = resp_rdata_q;
  assign bus.o_csr_resp_exception = resp_exc_q;
  assign o_wfi_wake               = wfi_q;

endmodule
